// File: rtl/led_seq_pkg.sv
// Shared mode encoding, initial patterns and the per-step pattern function
// for the LED bank sequencer.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_RUN1  = 2'd0,
        MODE_RUN2  = 2'd1,
        MODE_FILL  = 2'd2,
        MODE_BLINK = 2'd3
    } mode_e;

    localparam logic [7:0] INIT_RUN1  = 8'h01;
    localparam logic [7:0] INIT_RUN2  = 8'h03;
    localparam logic [7:0] INIT_FILL  = 8'h01;
    localparam logic [7:0] INIT_BLINK = 8'hFF;

    function automatic logic [7:0] init_pattern(input mode_e mode);
        logic [7:0] p;
        case (mode)
            MODE_RUN1:  p = INIT_RUN1;
            MODE_RUN2:  p = INIT_RUN2;
            MODE_FILL:  p = INIT_FILL;
            default:    p = INIT_BLINK;
        endcase
        return p;
    endfunction

    // FILL shifts ones in from the bottom; an all-ones bar clears, and the
    // shift of an empty bar naturally restarts at 8'h01.
    function automatic logic [7:0] next_pattern(input mode_e mode, input logic [7:0] led);
        logic [7:0] p;
        case (mode)
            MODE_RUN1,
            MODE_RUN2:  p = {led[6:0], led[7]};
            MODE_FILL:  p = (led == 8'hFF) ? 8'h00 : {led[6:0], 1'b1};
            default:    p = ~led;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Step-rate prescaler: counts 0..DIV-1 while enabled and pulses tick on the
// last count; clr and rs both return the count to zero.
module tick_prescaler #(
    parameter int DIV = 25_000_000
) (
    input  logic clki,
    input  logic rs,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] CNT_MAX = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_MAX) && en;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clki) begin
        if (rs) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED bank sequencer: the mode register is the FSM state; each prescaler
// tick advances the LED register through the current mode's pattern.
//
//   state      | meaning
//   MODE_RUN1  | single LED rotating left
//   MODE_RUN2  | adjacent LED pair rotating left
//   MODE_FILL  | bar grows from bit 0, clears after full, restarts
//   MODE_BLINK | whole bank toggles
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int DIV = 25_000_000
) (
    input  logic       clki,
    input  logic       rs,
    input  logic [1:0] mode_sel,
    input  logic       mode_load,
    input  logic       pause,
    output logic [7:0] led,
    output logic [1:0] mode,
    output logic       step_tick
);

    mode_e      state_q, state_d;
    logic [7:0] led_q, led_d;
    logic       step_q, step_d;
    logic       tick;

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clki (clki),
        .rs   (rs),
        .en   (!pause),
        .clr  (mode_load),
        .tick (tick)
    );

    // A load takes priority over a coincident tick, so the restarted
    // pattern is never stepped in the same cycle.
    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        step_d  = 1'b0;
        if (mode_load) begin
            state_d = mode_e'(mode_sel);
            led_d   = init_pattern(mode_e'(mode_sel));
        end else if (tick) begin
            led_d   = next_pattern(state_q, led_q);
            step_d  = 1'b1;
        end
    end

    always_ff @(posedge clki) begin
        if (rs) begin
            state_q <= MODE_RUN1;
            led_q   <= INIT_RUN1;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            led_q   <= led_d;
            step_q  <= step_d;
        end
    end

    assign led       = led_q;
    assign mode      = state_q;
    assign step_tick = step_q;

endmodule

// File: doc/led_pattern_sequencer.md
# led_pattern_sequencer

Sequencer for the 8-LED bank: owns the LED output register and steps it through one of four selectable patterns (single running LED, two adjacent running LEDs, bar fill, full blink) at a rate set by a clock prescaler. It sits between the board clock/reset and the `led[7:0]` pins. It replaces fixed-pattern top logic so that mode selection and pause come from switches or a host.

## Interface
- `DIV`, default 25_000_000: clock cycles per pattern step, DIV ≥ 1. Benches use DIV=4.
- `clki` in 1: system clock; all logic on the rising edge.
- `rs` in 1: reset, synchronous, active-high.
- `mode_sel` in 2: requested mode. 0=RUN1, 1=RUN2, 2=FILL, 3=BLINK.
- `mode_load` in 1: one-cycle strobe; captures `mode_sel`.
- `pause` in 1: while high, freezes the prescaler and the pattern.
- `led` out 8: LED drive, registered.
- `mode` out 2: current mode, registered.
- `step_tick` out 1: registered one-cycle pulse, high in the first cycle a new stepped pattern is visible on `led`.

## Operation
- Reset (`rs`=1 at an edge): mode=RUN1, `led`=8'h01, prescaler=0, `step_tick`=0.
  - Reset overrides all other inputs, including mid-pattern and during pause.
- Prescaler: `cnt` counts 0..DIV-1 while `pause`=0.
  - tick = (cnt==DIV-1) && !pause; `cnt` wraps to 0 on tick.
  - Width is max(1, clog2(DIV)). DIV=1 gives a tick every unpaused cycle.
- FSM: one state per mode. Transitions occur only via `mode_load`. Per-tick next pattern:
  - RUN1: rotate left by 1 (8'h80 → 8'h01).
  - RUN2: rotate left by 1, starting from 8'h03 (8'hC0 → 8'h81 → 8'h03).
  - FILL: led = {led[6:0],1'b1} until 8'hFF; 8'hFF → 8'h00; 8'h00 → 8'h01.
  - BLINK: bitwise invert; initial 8'hFF.
- Mode load (`mode_load`=1, not in reset): next edge sets mode=`mode_sel`, led=initial pattern (RUN1 01, RUN2 03, FILL 01, BLINK FF), cnt=0, `step_tick`=0.
  - Reloading the current mode also restarts it.
- Simultaneous events:
  - `mode_load` with tick: load wins; no step.
  - `mode_load` with `pause`: load still takes effect; the pattern then stays frozen.
- Pause: `led`, `mode` and `cnt` hold; `step_tick`=0. On release, counting resumes from the held `cnt`.
- `mode_sel` is ignored when `mode_load` is 0.

## Timing
- Step latency: a tick at edge N updates `led` and raises `step_tick` after edge N. `step_tick` drops after edge N+1 unless DIV=1.
- After reset deasserts, the first step is visible DIV cycles later. Steps then repeat every DIV cycles while unpaused.
- `mode_load` latency: 1 cycle to the new mode and initial pattern. The first step of the new mode follows DIV cycles after that.
- Periods in ticks: RUN1 8, RUN2 8, FILL 9 (01..FF, 00), BLINK 2.
- No combinational path from inputs to outputs.

## Structure
- Package `led_seq_pkg`:
  - Mode constants MODE_RUN1..MODE_BLINK (2-bit).
  - Initial-pattern constants INIT_RUN1=8'h01, INIT_RUN2=8'h03, INIT_FILL=8'h01, INIT_BLINK=8'hFF.
  - A function `next_pattern(mode, led)`.
- Sub-module `tick_prescaler`:
  - Parameter DIV; ports `clki`, `rs`, `en` (= !pause), `clr` (= mode_load); output `tick`.
  - Its counter state must match the rules above.
- The top of the block holds the mode register, the `led` register and the `step_tick` register.

## Test plan
All scenarios use DIV=4 and a 20 ns clock.
- Reset then run: `rs`=1 for 5 cycles, then 0 → `led` reads 01 for 4 cycles, then 02, 04, … 80, 01, each step 4 cycles apart; `step_tick` pulses with each change.
- RUN2 wrap: `mode_load` with `mode_sel`=1 → `led`=03 the next cycle; over 8 steps sequence 06, 0C, 18, 30, 60, C0, 81, 03.
- FILL and BLINK:
  - FILL gives 01, 03, 07, … FF, 00, 01.
  - BLINK gives FF, 00, FF at 4-cycle spacing.
  - `mode` output matches `mode_sel` each time.
- Pause: assert `pause` at cnt=2 for 10 cycles → `led` frozen and no `step_tick`. After release, the next step occurs 2 cycles later (cnt 2→3 → tick).
- Collision: `mode_load`(BLINK) in the tick cycle of RUN1 with `led`=08 → `led`=FF, no 10 appears, and `step_tick`=0. The next step comes 4 cycles later.
- Mid-operation reset: `rs`=1 for 1 cycle during FILL with `led`=1F while paused → `led`=01, `mode`=0, and counting restarts, so the first step comes 4 cycles after `rs` falls if `pause` is low.
